regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 136 +++++++++++++
 tb/tb_regfile_param.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parameterised register file with one write port, two combinational read
//   ports and a sequential clear sweep that zeroes one register per cycle.
//
// Parameters
//   DATA_W   register width in bits
//   ADDR_W   address width; DEPTH = 2**ADDR_W registers
//   ZERO_R0  1 = register 0 is hard-wired to zero (writes dropped)
//   BYPASS   1 = a read of the register being written returns wr_data
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears registers and control)
//   wr_en     write request
//   wr_addr   write destination register
//   wr_data   write data
//   wr_ready  write accepted this cycle (low while a clear sweep is busy)
//   rd_addr1  read port 1 address
//   rd_data1  read port 1 data (combinational)
//   rd_addr2  read port 2 address
//   rd_data2  read port 2 data (combinational)
//   clr_req   start a clear sweep (sampled only when idle)
//   clr_busy  sweep in progress (CLEAR or DONE)
//   clr_done  one-cycle pulse when the sweep has finished
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Sweep stops on the last index instead of wrapping back to 0.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_fire;

    // Combined forwarding / zero-register selection for one read port.
    function automatic logic [DATA_W-1:0] rd_sel(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              fwd_en,
        input logic [ADDR_W-1:0] fwd_addr,
        input logic [DATA_W-1:0] fwd_data
    );
        logic [DATA_W-1:0] v;
        v = stored;
        if ((BYPASS != 0) && fwd_en && (fwd_addr == addr)) begin
            v = fwd_data;
        end
        if ((ZERO_R0 != 0) && (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    assign wr_ready = (state == S_IDLE);
    assign clr_busy = (state != S_IDLE);
    assign clr_done = (state == S_DONE);

    // Accepted write that actually lands in storage; r0 is excluded when
    // hard-wired so that neither storage nor bypass ever sees it.
    assign wr_fire = wr_en && wr_ready && !((ZERO_R0 != 0) && (wr_addr == '0));

    assign rd_data1 = rd_sel(rd_addr1, mem[rd_addr1], wr_fire, wr_addr, wr_data);
    assign rd_data2 = rd_sel(rd_addr2, mem[rd_addr2], wr_fire, wr_addr, wr_data);

    // Control: IDLE -> CLEAR (DEPTH cycles) -> DONE (1 cycle) -> IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == LAST_IDX) begin
                        state <= S_DONE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Storage: the sweep owns the array while clearing; wr_fire is already
    // blocked then because wr_ready is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == S_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//   Three instances: u0 (32b x 4, bypass, no zero-r0), u1 (32b x 4, no
//   bypass, zero-r0) sharing one stimulus set, and u2 (8b x 8, bypass).
//   A phase-based reference model predicts every output.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Group A stimulus (u0, u1)
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_addr1 = '0;
    logic [1:0]  rd_addr2 = '0;
    logic        clr_req = 1'b0;
    // Group B stimulus (u2)
    logic        b_wr_en = 1'b0;
    logic [2:0]  b_wr_addr = '0;
    logic [7:0]  b_wr_data = '0;
    logic [2:0]  b_rd_addr1 = '0;
    logic [2:0]  b_rd_addr2 = '0;
    logic        b_clr_req = 1'b0;

    logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
    logic [7:0]  b_rd1, b_rd2;
    logic        rdy0, busy0, done0, rdy1, busy1, done1, b_rdy, b_busy, b_done;

    regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(0), .BYPASS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(rdy0), .rd_addr1(rd_addr1),
        .rd_data1(rd1_0), .rd_addr2(rd_addr2), .rd_data2(rd2_0),
        .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0));

    regfile_param #(.DATA_W(32), .ADDR_W(2), .ZERO_R0(1), .BYPASS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ready(rdy1), .rd_addr1(rd_addr1),
        .rd_data1(rd1_1), .rd_addr2(rd_addr2), .rd_data2(rd2_1),
        .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1));

    regfile_param #(.DATA_W(8), .ADDR_W(3), .ZERO_R0(0), .BYPASS(1)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_ready(b_rdy), .rd_addr1(b_rd_addr1),
        .rd_data1(b_rd1), .rd_addr2(b_rd_addr2), .rd_data2(b_rd2),
        .clr_req(b_clr_req), .clr_busy(b_busy), .clr_done(b_done));

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // ph = 0 idle; 1..DEPTH = clearing register ph-1; DEPTH+1 = done cycle.
    logic [31:0] mdl [3][8];
    int          ph [3];
    int          depth [3] = '{4, 4, 8};
    int          z0 [3]    = '{0, 1, 0};
    int          byp [3]   = '{1, 0, 1};

    function automatic logic m_we(int i);
        return (i < 2) ? wr_en : b_wr_en;
    endfunction
    function automatic int m_wa(int i);
        return (i < 2) ? int'(wr_addr) : int'(b_wr_addr);
    endfunction
    function automatic logic [31:0] m_wd(int i);
        return (i < 2) ? wr_data : {24'h0, b_wr_data};
    endfunction
    function automatic logic m_cr(int i);
        return (i < 2) ? clr_req : b_clr_req;
    endfunction

    function automatic logic [31:0] exp_rd(int i, int a);
        logic [31:0] v;
        v = mdl[i][a];
        if (byp[i] != 0 && ph[i] == 0 && m_we(i) && m_wa(i) == a && !(z0[i] != 0 && a == 0))
            v = m_wd(i);
        if (z0[i] != 0 && a == 0) v = '0;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ph[i] = 0;
            for (int a = 0; a < 8; a++) mdl[i][a] = '0;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            if (ph[i] == 0) begin
                if (m_we(i) && !(z0[i] != 0 && m_wa(i) == 0)) mdl[i][m_wa(i)] = m_wd(i);
                if (m_cr(i)) ph[i] = 1;
            end else if (ph[i] <= depth[i]) begin
                mdl[i][ph[i]-1] = '0;
                ph[i]++;
            end else begin
                ph[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; clr_req = 0; b_wr_en = 0; b_clr_req = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        model_reset();
        #1;
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = a[1:0]; rd_addr2 = a[1:0]; #1;
            checks++;
            if (rd1_0 !== 32'h0 || rd2_0 !== 32'h0 || rd1_1 !== 32'h0) begin
                failures++;
                $display("FAIL reset_regs a=%0d got=%h/%h/%h exp=0", a, rd1_0, rd2_0, rd1_1);
            end
        end
        checks++;
        if ({rdy0, busy0, done0, b_rdy, b_busy, b_done} !== 6'b100100) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=100100", {rdy0, busy0, done0, b_rdy, b_busy, b_done});
        end
        tick(); tick();
        #2 rst_n = 1;
        tick();
    endtask

    task automatic test_basic();
        wr_en = 1; wr_addr = 2; wr_data = 32'hDEADBEEF;
        tick();
        wr_en = 0; rd_addr1 = 2; rd_addr2 = 2; #1;
        checks++;
        if (rd1_0 !== 32'hDEADBEEF || rd2_0 !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL basic_r2 got=%h/%h exp=deadbeef", rd1_0, rd2_0);
        end
        for (int a = 0; a < 4; a++) begin
            if (a == 2) continue;
            rd_addr1 = a[1:0]; #1;
            checks++;
            if (rd1_0 !== 32'h0) begin
                failures++;
                $display("FAIL basic_other a=%0d got=%h exp=0", a, rd1_0);
            end
        end
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 1; wr_data = 32'h12345678; rd_addr1 = 1; #1;
        checks++;
        if (rd1_0 !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_on got=%h exp=12345678", rd1_0);
        end
        checks++;
        if (rd1_1 !== 32'h0) begin
            failures++;
            $display("FAIL bypass_off_pre got=%h exp=0", rd1_1);
        end
        tick();
        wr_en = 0; #1;
        checks++;
        if (rd1_1 !== 32'h12345678 || rd1_0 !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_post got=%h/%h exp=12345678", rd1_0, rd1_1);
        end
    endtask

    task automatic test_zero_r0();
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF; rd_addr1 = 0; #1;
        checks++;
        if (rd1_1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_r0_pre got=%h exp=0", rd1_1);
        end
        tick();
        wr_en = 0; #1;
        checks++;
        if (rd1_1 !== 32'h0) begin
            failures++;
            $display("FAIL zero_r0_post got=%h exp=0", rd1_1);
        end
        checks++;
        if (rd1_0 !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL zero_r0_plain got=%h exp=ffffffff", rd1_0);
        end
    endtask

    task automatic test_clear();
        int nbusy, done_at, ndone;
        for (int a = 0; a < 4; a++) begin
            wr_en = 1; wr_addr = a[1:0]; wr_data = 32'(a + 1);
            tick();
        end
        wr_en = 0; clr_req = 1;
        tick();
        clr_req = 0;
        nbusy = 0; done_at = 0; ndone = 0;
        while (busy0 && nbusy < 30) begin
            nbusy++;
            if (done0) begin ndone++; done_at = nbusy; end
            checks++;
            if (rdy0 !== 1'b0) begin
                failures++;
                $display("FAIL clear_ready cyc=%0d got=%b exp=0", nbusy, rdy0);
            end
            wr_en = (nbusy == 1); wr_addr = 3; wr_data = 32'h55;
            clr_req = (nbusy == 2);
            tick();
            wr_en = 0; clr_req = 0;
        end
        checks++;
        if (nbusy != 5 || ndone != 1 || done_at != 5) begin
            failures++;
            $display("FAIL clear_timing busy=%0d done=%0d at=%0d exp=5/1/5", nbusy, ndone, done_at);
        end
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = a[1:0]; #1;
            checks++;
            if (rd1_0 !== 32'h0 || busy0 !== 1'b0) begin
                failures++;
                $display("FAIL clear_after a=%0d got=%h busy=%b exp=0", a, rd1_0, busy0);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        int nbusy, ndone;
        for (int a = 0; a < 4; a++) begin
            wr_en = 1; wr_addr = a[1:0]; wr_data = 32'hA0 + 32'(a);
            tick();
        end
        wr_en = 0; clr_req = 1;
        tick();
        clr_req = 0;
        tick(); tick();
        #2 rst_n = 0;
        model_reset();
        #1;
        ndone = 0;
        for (int a = 0; a < 4; a++) begin
            rd_addr1 = a[1:0]; #1;
            checks++;
            if (rd1_0 !== 32'h0) begin
                failures++;
                $display("FAIL midrst_regs a=%0d got=%h exp=0", a, rd1_0);
            end
        end
        checks++;
        if (busy0 !== 1'b0 || rdy0 !== 1'b1) begin
            failures++;
            $display("FAIL midrst_ctrl busy=%b rdy=%b exp=0/1", busy0, rdy0);
        end
        for (int c = 0; c < 3; c++) begin
            if (done0) ndone++;
            tick();
        end
        #2 rst_n = 1;
        wr_en = 1; wr_addr = 3; wr_data = 32'h77;
        tick();
        wr_en = 0; rd_addr1 = 3; #1;
        checks++;
        if (rd1_0 !== 32'h77) begin
            failures++;
            $display("FAIL first_write got=%h exp=77", rd1_0);
        end
        clr_req = 1;
        tick();
        clr_req = 0;
        nbusy = 0;
        while (busy0 && nbusy < 30) begin
            nbusy++;
            if (done0) ndone++;
            tick();
        end
        checks++;
        if (nbusy != 5 || ndone != 1) begin
            failures++;
            $display("FAIL midrst_resweep busy=%0d done=%0d exp=5/1", nbusy, ndone);
        end
    endtask

    task automatic test_wide();
        int nbusy;
        b_wr_en = 1; b_wr_addr = 7; b_wr_data = 8'hA5;
        tick();
        b_wr_en = 0; b_rd_addr1 = 7; #1;
        checks++;
        if (b_rd1 !== 8'hA5) begin
            failures++;
            $display("FAIL wide_write got=%h exp=a5", b_rd1);
        end
        b_clr_req = 1;
        tick();
        b_clr_req = 0;
        nbusy = 0;
        while (b_busy && nbusy < 40) begin
            nbusy++;
            tick();
        end
        checks++;
        if (nbusy != 9 || b_rd1 !== 8'h00) begin
            failures++;
            $display("FAIL wide_clear busy=%0d r7=%h exp=9/00", nbusy, b_rd1);
        end
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        for (int c = 0; c < 400; c++) begin
            wr_en = $urandom_range(0, 1); wr_addr = 2'($urandom_range(0, 3));
            wr_data = $urandom; rd_addr1 = 2'($urandom_range(0, 3));
            rd_addr2 = 2'($urandom_range(0, 3)); clr_req = ($urandom_range(0, 19) == 0);
            b_wr_en = $urandom_range(0, 1); b_wr_addr = 3'($urandom_range(0, 7));
            b_wr_data = 8'($urandom); b_rd_addr1 = 3'($urandom_range(0, 7));
            b_rd_addr2 = 3'($urandom_range(0, 7)); b_clr_req = ($urandom_range(0, 29) == 0);
            #1;
            e1 = exp_rd(0, int'(rd_addr1)); e2 = exp_rd(0, int'(rd_addr2));
            checks++;
            if (rd1_0 !== e1 || rd2_0 !== e2 || rdy0 !== (ph[0] == 0) ||
                busy0 !== (ph[0] != 0) || done0 !== (ph[0] == 5)) begin
                failures++;
                $display("FAIL rand_u0 c=%0d got=%h/%h/%b%b%b exp=%h/%h ph=%0d",
                         c, rd1_0, rd2_0, rdy0, busy0, done0, e1, e2, ph[0]);
            end
            e1 = exp_rd(1, int'(rd_addr1)); e2 = exp_rd(1, int'(rd_addr2));
            checks++;
            if (rd1_1 !== e1 || rd2_1 !== e2 || rdy1 !== (ph[1] == 0) ||
                busy1 !== (ph[1] != 0) || done1 !== (ph[1] == 5)) begin
                failures++;
                $display("FAIL rand_u1 c=%0d got=%h/%h/%b%b%b exp=%h/%h ph=%0d",
                         c, rd1_1, rd2_1, rdy1, busy1, done1, e1, e2, ph[1]);
            end
            e1 = exp_rd(2, int'(b_rd_addr1)); e2 = exp_rd(2, int'(b_rd_addr2));
            checks++;
            if ({24'h0, b_rd1} !== e1 || {24'h0, b_rd2} !== e2 || b_rdy !== (ph[2] == 0) ||
                b_busy !== (ph[2] != 0) || b_done !== (ph[2] == 9)) begin
                failures++;
                $display("FAIL rand_u2 c=%0d got=%h/%h/%b%b%b exp=%h/%h ph=%0d",
                         c, b_rd1, b_rd2, b_rdy, b_busy, b_done, e1, e2, ph[2]);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_bypass();
        test_zero_r0();
        test_clear();
        test_reset_mid_sweep();
        test_wide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
